// File: rtl/muldiv_hilo_ctrl.sv
// Iterative multiply/divide sequencer owning the HI/LO pair.
// One-bit-per-cycle shift-add multiply and restoring divide, with a one-cycle sign fix-up.
module muldiv_hilo_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              mf_req,
  output logic              busy,
  output logic              stall,
  output logic              hilo_we,
  output logic [DATA_W-1:0] lo_out,
  output logic [DATA_W-1:0] hi_out,
  output logic              div_zero
);

  localparam int unsigned PW = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] acc, mq, mcand;
  logic [CNT_W-1:0]  cnt;
  logic              is_div, neg_res, neg_rem;

  logic              op_div, op_signed, a_neg, b_neg, divz;
  logic [DATA_W-1:0] a_abs, b_abs;
  logic [DATA_W:0]   mul_sum, div_sh, div_trial;
  logic [DATA_W-1:0] iter_acc, iter_mq;
  logic [PW-1:0]     prod, prod_fix;
  logic [DATA_W-1:0] fix_lo, fix_hi;

  // Operand decode at issue: magnitudes plus sign bits for the signed ops.
  always_comb begin
    op_div    = op[1];
    op_signed = ~op[0];
    a_neg     = op_signed & rs_data[DATA_W-1];
    b_neg     = op_signed & rt_data[DATA_W-1];
    a_abs     = a_neg ? -rs_data : rs_data;
    b_abs     = b_neg ? -rt_data : rt_data;
    divz      = op_div & (rt_data == '0);
  end

  // One iteration: acc is the upper accumulator / partial remainder, mq the multiplier / quotient.
  always_comb begin
    mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
    div_sh    = {acc, mq[DATA_W-1]};
    div_trial = div_sh - {1'b0, mcand};
    if (is_div) begin
      if (!div_trial[DATA_W]) begin
        iter_acc = div_trial[DATA_W-1:0];
        iter_mq  = {mq[DATA_W-2:0], 1'b1};
      end else begin
        iter_acc = div_sh[DATA_W-1:0];
        iter_mq  = {mq[DATA_W-2:0], 1'b0};
      end
    end else begin
      iter_acc = mul_sum[DATA_W:1];
      iter_mq  = {mul_sum[0], mq[DATA_W-1:1]};
    end
  end

  // Sign restoration; the remainder follows the dividend's sign.
  always_comb begin
    prod     = {acc, mq};
    prod_fix = neg_res ? -prod : prod;
    if (is_div) begin
      fix_lo = neg_res ? -mq : mq;
      fix_hi = neg_rem ? -acc : acc;
    end else begin
      fix_lo = prod_fix[DATA_W-1:0];
      fix_hi = prod_fix[PW-1:DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = divz ? DONE : CALC;
      CALC:    if (cnt == CNT_W'(DATA_W - 1)) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    hilo_we = (state == DONE);
    stall   = mf_req & (busy | start);
  end

  // Datapath and result registers; HI/LO load only on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      mq       <= '0;
      mcand    <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      lo_out   <= '0;
      hi_out   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc      <= '0;
          mq       <= op_div ? a_abs : b_abs;
          mcand    <= op_div ? b_abs : a_abs;
          cnt      <= '0;
          is_div   <= op_div;
          neg_res  <= a_neg ^ b_neg;
          neg_rem  <= a_neg;
          div_zero <= divz;
          if (divz) begin
            lo_out <= '1;
            hi_out <= rs_data;
          end
        end
        CALC: begin
          acc <= iter_acc;
          mq  <= iter_mq;
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          lo_out <= fix_lo;
          hi_out <= fix_hi;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl: latency, results, stall, ignored starts and reset abort.
module tb_muldiv_hilo_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, mf_req;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        busy, stall, hilo_we, div_zero;
  logic [31:0] lo_out, hi_out;

  int checks = 0;
  int passes = 0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  muldiv_hilo_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .mf_req(mf_req),
    .busy(busy), .stall(stall), .hilo_we(hilo_we),
    .lo_out(lo_out), .hi_out(hi_out), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the cycle after DONE.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] elo,
                        input logic [31:0] ehi, input logic edz, input logic mf,
                        input logic poke);
    int  n;
    int  bad_busy;
    int  bad_stall;
    bit  seen;
    op = o; rs_data = a; rt_data = b; mf_req = mf; start = 1'b1;
    #1;
    if (mf) chk({tag, "_stall_at_start"}, 32'(stall), 32'd1);
    n = 0; seen = 0; bad_busy = 0; bad_stall = 0;
    while (!seen && n < 100) begin
      @(posedge clk); @(negedge clk);
      n++;
      start = poke && (n >= 3 && n <= 6);
      #1;
      if (hilo_we) seen = 1;
      if (!busy) bad_busy++;
      if (stall !== mf) bad_stall++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_busy_window"}, 32'(bad_busy), 32'd0);
    chk({tag, "_stall_window"}, 32'(bad_stall), 32'd0);
    chk({tag, "_lo"}, lo_out, elo);
    chk({tag, "_hi"}, hi_out, ehi);
    chk({tag, "_div_zero"}, 32'(div_zero), 32'(edz));
    start = poke;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    #1;
    chk({tag, "_we_drop"}, 32'(hilo_we), 32'd0);
    chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
    chk({tag, "_stall_drop"}, 32'(stall), 32'd0);
    chk({tag, "_lo_held"}, lo_out, elo);
    mf_req = 1'b0;
  endtask

  initial begin
    int we_cnt;
    reset = 1'b1; start = 1'b0; mf_req = 1'b0; op = MULT; rs_data = '0; rt_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(hilo_we), 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    @(negedge clk);

    run_op("mult_7_m3", MULT, 32'd7, 32'hFFFF_FFFD, 34, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op("divu_by0", DIVU, 32'd100, 32'd0, 1, 32'hFFFF_FFFF, 32'h0000_0064, 1'b1, 1'b0, 1'b0);
    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 34, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 1'b0);
    run_op("mult_m4_m5", MULT, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 34, 32'd20, 32'd0, 1'b0, 1'b0, 1'b0);
    run_op("div_100_m7", DIV, 32'd100, 32'hFFFF_FFF9, 34, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0, 1'b0);
    run_op("mf_poke", MULTU, 32'd1000, 32'd3000, 34, 32'd3000000, 32'd0, 1'b0, 1'b1, 1'b1);

    // Any start accepted while busy would produce a second write strobe here.
    we_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (hilo_we) we_cnt++;
    end
    chk("poke_no_extra_we", 32'(we_cnt), 32'd0);

    // Reset during cycle T+10 of a MULTU aborts it.
    op = MULTU; rs_data = 32'h1234_5678; rt_data = 32'h9ABC_DEF0; start = 1'b1;
    we_cnt = 0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); @(negedge clk);
      if (hilo_we) we_cnt++;
    end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_lo", lo_out, 32'd0);
    chk("abort_hi", hi_out, 32'd0);
    repeat (40) begin
      @(negedge clk);
      if (hilo_we) we_cnt++;
    end
    chk("abort_no_we", 32'(we_cnt), 32'd0);
    run_op("after_abort", MULTU, 32'd3, 32'd5, 34, 32'd15, 32'd0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
